// File: rtl/brick_pkg.sv
// Shared constants and state encoding for the ball motion logic.
`default_nettype none

package brick_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_BALL  = 3'b111;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        S_IDLE       = 3'd0,
        S_WAIT_FRAME = 3'd1,
        S_ERASE_LOAD = 3'd2,
        S_ERASE_RUN  = 3'd3,
        S_MOVE       = 3'd4,
        S_DRAW_LOAD  = 3'd5,
        S_DRAW_RUN   = 3'd6,
        S_LOST       = 3'd7
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ball_step_calc.sv
// Combinational next-position calculation: bounce requests, wall reflection, bottom loss.
`default_nettype none

module ball_step_calc #(
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120,
    parameter int BALL_SIZE = 4
) (
    input  logic [7:0] x_i,
    input  logic [6:0] y_i,
    input  logic       dx_neg_i,
    input  logic       dy_neg_i,
    input  logic       bounce_x_i,
    input  logic       bounce_y_i,
    output logic [7:0] nx_o,
    output logic [6:0] ny_o,
    output logic       ndx_neg_o,
    output logic       ndy_neg_o,
    output logic       lost_o
);

    localparam logic signed [8:0] W_S  = $signed(9'(SCREEN_W));
    localparam logic signed [8:0] H_S  = $signed(9'(SCREEN_H));
    localparam logic signed [8:0] SZ_S = $signed(9'(BALL_SIZE));

    logic              dx_neg;
    logic              dy_neg;
    logic signed [8:0] x_ext;
    logic signed [8:0] y_ext;
    logic signed [8:0] x_try;
    logic signed [8:0] y_try;
    logic              x_hit;
    logic              y_hit;

    // A reflected move equals one step in the final direction, so the
    // result is always x +/- 1 once the final direction is known.
    always_comb begin
        dx_neg    = dx_neg_i ^ bounce_x_i;
        dy_neg    = dy_neg_i ^ bounce_y_i;
        x_ext     = $signed({1'b0, x_i});
        y_ext     = $signed({2'b00, y_i});
        x_try     = dx_neg ? (x_ext - 9'sd1) : (x_ext + 9'sd1);
        y_try     = dy_neg ? (y_ext - 9'sd1) : (y_ext + 9'sd1);
        x_hit     = (x_try < 9'sd0) || ((x_try + SZ_S) > W_S);
        y_hit     = (y_try < 9'sd0);
        ndx_neg_o = dx_neg ^ x_hit;
        ndy_neg_o = dy_neg ^ y_hit;
        nx_o      = ndx_neg_o ? (x_i - 8'd1) : (x_i + 8'd1);
        ny_o      = ndy_neg_o ? (y_i - 7'd1) : (y_i + 7'd1);
        lost_o    = ($signed({2'b00, ny_o}) + SZ_S) > H_S;
    end

endmodule

`default_nettype wire

// File: rtl/ball_mover.sv
// Ball motion controller: erase at old position, move with reflection, redraw.
`default_nettype none

module ball_mover #(
    parameter int         SCREEN_W        = brick_pkg::SCREEN_W,
    parameter int         SCREEN_H        = brick_pkg::SCREEN_H,
    parameter int         BALL_SIZE       = 4,
    parameter int         START_X         = 78,
    parameter int         START_Y         = 60,
    parameter int         FRAMES_PER_STEP = 2,
    parameter logic [2:0] BALL_COLOUR     = brick_pkg::COL_BALL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic       draw_done,
    input  logic       bounce_x,
    input  logic       bounce_y,
    output logic       go,
    output logic       draw,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [6:0] size,
    output logic [2:0] colour,
    output logic       ball_lost
);

    import brick_pkg::*;

    state_t     state_q, state_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic       dxn_q, dxn_d;
    logic       dyn_q, dyn_d;
    logic       bx_q, bx_d;
    logic       by_q, by_d;
    logic       lost_q, lost_d;
    logic [7:0] fcnt_q, fcnt_d;

    logic [7:0] calc_nx;
    logic [6:0] calc_ny;
    logic       calc_ndxn;
    logic       calc_ndyn;
    logic       calc_lost;

    ball_step_calc #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .BALL_SIZE(BALL_SIZE)
    ) u_calc (
        .x_i       (x_q),
        .y_i       (y_q),
        .dx_neg_i  (dxn_q),
        .dy_neg_i  (dyn_q),
        .bounce_x_i(bx_q),
        .bounce_y_i(by_q),
        .nx_o      (calc_nx),
        .ny_o      (calc_ny),
        .ndx_neg_o (calc_ndxn),
        .ndy_neg_o (calc_ndyn),
        .lost_o    (calc_lost)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= 8'(START_X);
            y_q     <= 7'(START_Y);
            dxn_q   <= 1'b0;
            dyn_q   <= 1'b1;
            bx_q    <= 1'b0;
            by_q    <= 1'b0;
            lost_q  <= 1'b0;
            fcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dxn_q   <= dxn_d;
            dyn_q   <= dyn_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            lost_q  <= lost_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dxn_d   = dxn_q;
        dyn_d   = dyn_q;
        bx_d    = bx_q | bounce_x;
        by_d    = by_q | bounce_y;
        lost_d  = lost_q;
        fcnt_d  = fcnt_q;
        go      = 1'b0;
        draw    = 1'b1;
        colour  = COL_BLACK;

        case (state_q)
            S_IDLE: begin
                fcnt_d = 8'd0;
                if (enable) state_d = S_DRAW_LOAD;
            end
            S_WAIT_FRAME: begin
                if (!enable) begin
                    fcnt_d  = 8'd0;
                    state_d = S_IDLE;
                end else if (frame_tick) begin
                    if (fcnt_q == 8'(FRAMES_PER_STEP - 1)) begin
                        fcnt_d  = 8'd0;
                        state_d = S_ERASE_LOAD;
                    end else begin
                        fcnt_d = fcnt_q + 8'd1;
                    end
                end
            end
            S_ERASE_LOAD: begin
                go      = 1'b1;
                state_d = S_ERASE_RUN;
            end
            S_ERASE_RUN: begin
                draw = 1'b0;
                if (draw_done) state_d = S_MOVE;
            end
            S_MOVE: begin
                // Latches are consumed here; a pulse in this very cycle survives.
                bx_d = bounce_x;
                by_d = bounce_y;
                if (calc_lost) begin
                    lost_d  = 1'b1;
                    state_d = S_LOST;
                end else begin
                    x_d     = calc_nx;
                    y_d     = calc_ny;
                    dxn_d   = calc_ndxn;
                    dyn_d   = calc_ndyn;
                    state_d = S_DRAW_LOAD;
                end
            end
            S_DRAW_LOAD: begin
                go      = 1'b1;
                colour  = BALL_COLOUR;
                state_d = S_DRAW_RUN;
            end
            S_DRAW_RUN: begin
                draw   = 1'b0;
                colour = BALL_COLOUR;
                if (draw_done) state_d = S_WAIT_FRAME;
            end
            S_LOST: begin
                if (!enable) begin
                    x_d     = 8'(START_X);
                    y_d     = 7'(START_Y);
                    dxn_d   = 1'b0;
                    dyn_d   = 1'b1;
                    lost_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign x_out     = x_q;
    assign y_out     = y_q;
    assign size      = 7'(BALL_SIZE);
    assign ball_lost = lost_q;

endmodule

`default_nettype wire

// File: tb/tb_ball_mover.sv
// Directed self-checking bench for ball_mover: start, stepping, walls, bounces, loss, reset.
`default_nettype none

module tb_ball_mover;

    localparam int W  = 160;
    localparam int H  = 120;
    localparam int SZ = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       frame_tick;
    logic       draw_done;
    logic       bounce_x;
    logic       bounce_y;
    logic       go;
    logic       draw;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [6:0] size;
    logic [2:0] colour;
    logic       ball_lost;

    int checks = 0;
    int errors = 0;
    int mx, my, mdx, mdy;

    ball_mover dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .frame_tick(frame_tick),
        .draw_done (draw_done),
        .bounce_x  (bounce_x),
        .bounce_y  (bounce_y),
        .go        (go),
        .draw      (draw),
        .x_out     (x_out),
        .y_out     (y_out),
        .size      (size),
        .colour    (colour),
        .ball_lost (ball_lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_go(input string tag);
        int n = 0;
        while (go !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_go_seen"}, 32'(go), 1);
    endtask

    task automatic pulse_tick();
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
    endtask

    task automatic model_reset();
        mx = 78; my = 60; mdx = 1; mdy = -1;
    endtask

    // Draw pass from IDLE at the start position.
    task automatic start_pass(input string tag);
        enable = 1'b1;
        wait_go(tag);
        check({tag, "_colour"}, 32'(colour), 7);
        check({tag, "_x"}, 32'(x_out), 78);
        check({tag, "_y"}, 32'(y_out), 60);
        check({tag, "_lost"}, 32'(ball_lost), 0);
        @(negedge clk);
        check({tag, "_draw_low"}, 32'(draw), 0);
        draw_done = 1'b1;
        @(negedge clk); draw_done = 1'b0;
        check({tag, "_draw_high"}, 32'(draw), 1);
    endtask

    // One full step: optional bounce pulses, two frames, erase, move, draw.
    task automatic step(input logic bx, input logic by);
        int  dx, dy, nx, ny;
        bit  lost;
        bit  saw_go;
        dx = bx ? -mdx : mdx;
        dy = by ? -mdy : mdy;
        nx = mx + dx;
        if (nx < 0 || nx + SZ > W) begin nx = mx - dx; dx = -dx; end
        ny = my + dy;
        if (ny < 0) begin dy = -dy; ny = my + 1; end
        lost = (ny + SZ > H);

        if (bx) begin @(negedge clk); bounce_x = 1'b1; @(negedge clk); bounce_x = 1'b0; end
        if (by) begin @(negedge clk); bounce_y = 1'b1; @(negedge clk); bounce_y = 1'b0; end
        pulse_tick();
        check("one_tick_no_go", 32'(go), 0);
        pulse_tick();
        wait_go("erase");
        check("erase_colour", 32'(colour), 0);
        check("erase_draw", 32'(draw), 1);
        check("erase_x", 32'(x_out), 32'(mx));
        check("erase_y", 32'(y_out), 32'(my));
        @(negedge clk);
        check("erase_run_go", 32'(go), 0);
        check("erase_run_draw", 32'(draw), 0);
        frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0; draw_done = 1'b1;
        @(negedge clk); draw_done = 1'b0;
        if (lost) begin
            saw_go = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (go) saw_go = 1'b1;
            end
            check("lost_no_draw", 32'(saw_go), 0);
            check("lost_flag", 32'(ball_lost), 1);
            check("lost_draw_hold", 32'(draw), 1);
            check("lost_x", 32'(x_out), 32'(mx));
            check("lost_y", 32'(y_out), 32'(my));
        end else begin
            wait_go("draw");
            check("draw_colour", 32'(colour), 7);
            check("draw_x", 32'(x_out), 32'(nx));
            check("draw_y", 32'(y_out), 32'(ny));
            @(negedge clk);
            check("draw_run_draw", 32'(draw), 0);
            draw_done = 1'b1;
            @(negedge clk); draw_done = 1'b0;
            check("draw_release", 32'(draw), 1);
            check("lost_clear", 32'(ball_lost), 0);
            mx = nx; my = ny; mdx = dx; mdy = dy;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; frame_tick = 1'b0; draw_done = 1'b0;
        bounce_x = 1'b0; bounce_y = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_go", 32'(go), 0);
        check("rst_draw", 32'(draw), 1);
        check("rst_colour", 32'(colour), 0);
        check("rst_lost", 32'(ball_lost), 0);
        check("rst_x", 32'(x_out), 78);
        check("rst_y", 32'(y_out), 60);
        check("size", 32'(size), 4);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_no_go", 32'(go), 0);

        start_pass("start");
        @(negedge clk); draw_done = 1'b1;
        @(negedge clk); draw_done = 1'b0;
        @(negedge clk);
        check("stray_done_go", 32'(go), 0);
        check("stray_done_draw", 32'(draw), 1);

        // Left wall: turn left with bounce_x, wiggle dy, run into x = 0.
        for (int s = 1; s <= 79; s++) begin
            step(s == 1, (s == 2) || (s == 3));
            if (s == 1)  begin check("p1s1_x", 32'(x_out), 77); check("p1s1_y", 32'(y_out), 59); end
            if (s == 3)  check("p1s3_y", 32'(y_out), 59);
            if (s == 63) check("top_wall_y", 32'(y_out), 1);
            if (s == 78) check("left_edge_x", 32'(x_out), 0);
            if (s == 79) begin check("left_wall_x", 32'(x_out), 1); check("p1s79_y", 32'(y_out), 17); end
        end

        // Reset in the middle of an erase pass.
        pulse_tick();
        pulse_tick();
        wait_go("pre_reset");
        @(negedge clk);
        check("erase_run_before_reset", 32'(draw), 0);
        reset = 1'b1;
        #1;
        check("mid_rst_go", 32'(go), 0);
        check("mid_rst_draw", 32'(draw), 1);
        check("mid_rst_x", 32'(x_out), 78);
        check("mid_rst_y", 32'(y_out), 60);
        @(negedge clk); reset = 1'b0;
        model_reset();
        start_pass("restart");

        // Right wall, coincident bounce, then run to the bottom.
        for (int s = 1; s <= 177; s++) begin
            step(s == 79, 1'b0);
            if (s == 1)   begin check("p2s1_x", 32'(x_out), 79); check("p2s1_y", 32'(y_out), 59); end
            if (s == 78)  check("right_edge_x", 32'(x_out), 156);
            if (s == 79)  check("coincident_x", 32'(x_out), 155);
            if (s == 80)  check("latch_empty_x", 32'(x_out), 154);
            if (s == 176) begin check("p2s176_x", 32'(x_out), 58); check("p2s176_y", 32'(y_out), 116); end
        end
        check("sticky_lost", 32'(ball_lost), 1);
        pulse_tick();
        pulse_tick();
        @(negedge clk);
        check("lost_ignores_ticks", 32'(go), 0);

        enable = 1'b0;
        @(negedge clk);
        check("relaunch_lost_clear", 32'(ball_lost), 0);
        check("relaunch_x", 32'(x_out), 78);
        check("relaunch_y", 32'(y_out), 60);
        model_reset();
        start_pass("relaunch");
        step(1'b0, 1'b0);
        check("relaunch_step_x", 32'(x_out), 79);
        check("relaunch_step_y", 32'(y_out), 59);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
